// File: rtl/calc_pkg.sv
// Shared constants and state encoding for the serial hex calculator
// command sequencer.
package calc_pkg;

    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_E     = 8'h45;
    localparam logic [7:0] CH_V     = 8'h56;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_STAR  = 8'h2A;
    localparam logic [7:0] CH_AMP   = 8'h26;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_AND = 2'd3;

    typedef enum logic [2:0] {
        ACC_A,
        ACC_B,
        DISCARD,
        CALC,
        WAIT_DONE,
        SEND
    } state_t;

endpackage

// File: rtl/calc_cmd_sequencer_hex_ascii_conv.sv
// Combinational ASCII <-> hex nibble conversion (accepts both letter
// cases on input, emits uppercase on output).
module hex_ascii_conv (
    input  logic [7:0] byte_in,
    output logic [3:0] nibble_out,
    output logic       is_hex,
    input  logic [3:0] nibble_in,
    output logic [7:0] char_out
);

    always_comb begin
        nibble_out = 4'h0;
        is_hex     = 1'b0;
        if (byte_in >= 8'h30 && byte_in <= 8'h39) begin
            nibble_out = 4'(byte_in - 8'h30);
            is_hex     = 1'b1;
        end else if (byte_in >= 8'h41 && byte_in <= 8'h46) begin
            nibble_out = 4'(byte_in - 8'h37);
            is_hex     = 1'b1;
        end else if (byte_in >= 8'h61 && byte_in <= 8'h66) begin
            nibble_out = 4'(byte_in - 8'h57);
            is_hex     = 1'b1;
        end
    end

    always_comb begin
        if (nibble_in < 4'd10) char_out = 8'h30 + {4'h0, nibble_in};
        else                   char_out = 8'h37 + {4'h0, nibble_in};
    end

endmodule

// File: rtl/calc_cmd_sequencer.sv
// Line parser / launcher / responder between the UART and the
// arithmetic unit of the serial hex calculator.
module calc_cmd_sequencer
    import calc_pkg::*;
#(
    parameter int         DIGITS = 4,
    parameter logic [7:0] TERM   = 8'h0D
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [9:0]          RX_DATA,
    input  logic                RX_DATA_EN,
    output logic [4*DIGITS-1:0] OP_A,
    output logic [4*DIGITS-1:0] OP_B,
    output logic [1:0]          OPCODE,
    output logic                CALC_START,
    input  logic                CALC_DONE,
    input  logic [4*DIGITS-1:0] CALC_RES,
    input  logic                CALC_OVF,
    output logic [7:0]          TX_DATA,
    output logic                TX_VALID,
    input  logic                TX_RDY,
    output logic                BUSY,
    output logic                RX_DROP
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int IW = $clog2(DIGITS + 2);
    localparam logic [CW-1:0] DIG_C = CW'(DIGITS);
    localparam logic [IW-1:0] DIG_I = IW'(DIGITS);

    state_t        state, state_d;
    logic [W-1:0]  op_a_d, op_b_d;
    logic [1:0]    opc_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [W-1:0]  res_q, res_d;
    logic          resp_num, num_d;
    logic [7:0]    resp_char, rch_d;
    logic [IW-1:0] idx, idx_d;
    logic [IW-1:0] last_idx;

    logic [7:0] rx_byte;
    logic       rx_flag;
    logic [3:0] rx_nib;
    logic       rx_hex;
    logic       is_op;
    logic [1:0] op_dec;
    logic       word_hex, word_op, word_term;
    logic [7:0] tx_char;
    logic [7:0] rx_char_nc;
    logic [3:0] tx_nib_nc;
    logic       tx_hex_nc;
    logic       unused_conv;

    assign rx_byte = RX_DATA[7:0];
    assign rx_flag = |RX_DATA[9:8];

    hex_ascii_conv u_rx_conv (
        .byte_in    (rx_byte),
        .nibble_out (rx_nib),
        .is_hex     (rx_hex),
        .nibble_in  (4'h0),
        .char_out   (rx_char_nc)
    );

    hex_ascii_conv u_tx_conv (
        .byte_in    (8'h00),
        .nibble_out (tx_nib_nc),
        .is_hex     (tx_hex_nc),
        .nibble_in  (res_q[W-1 -: 4]),
        .char_out   (tx_char)
    );

    assign unused_conv = ^{rx_char_nc, tx_nib_nc, tx_hex_nc};

    always_comb begin
        is_op  = 1'b1;
        op_dec = OP_ADD;
        unique case (rx_byte)
            CH_PLUS:  op_dec = OP_ADD;
            CH_MINUS: op_dec = OP_SUB;
            CH_STAR:  op_dec = OP_MUL;
            CH_AMP:   op_dec = OP_AND;
            default:  is_op  = 1'b0;
        endcase
    end

    // A parity or framing error disqualifies every character class.
    assign word_hex  = !rx_flag && rx_hex;
    assign word_op   = !rx_flag && is_op;
    assign word_term = !rx_flag && (rx_byte == TERM);

    always_comb begin
        state_d = state;
        op_a_d  = OP_A;
        op_b_d  = OP_B;
        opc_d   = OPCODE;
        cnt_d   = cnt;
        res_d   = res_q;
        num_d   = resp_num;
        rch_d   = resp_char;
        idx_d   = idx;
        unique case (state)
            ACC_A: begin
                if (RX_DATA_EN) begin
                    if (word_hex && cnt < DIG_C) begin
                        op_a_d = (OP_A << 4) | W'(rx_nib);
                        cnt_d  = cnt + CW'(1);
                    end else if (word_op && cnt != '0) begin
                        opc_d   = op_dec;
                        cnt_d   = '0;
                        op_b_d  = '0;
                        state_d = ACC_B;
                    end else if (word_term) begin
                        num_d   = 1'b0;
                        rch_d   = CH_E;
                        idx_d   = '0;
                        state_d = SEND;
                    end else begin
                        state_d = DISCARD;
                    end
                end
            end
            ACC_B: begin
                if (RX_DATA_EN) begin
                    if (word_hex && cnt < DIG_C) begin
                        op_b_d = (OP_B << 4) | W'(rx_nib);
                        cnt_d  = cnt + CW'(1);
                    end else if (word_term && cnt != '0) begin
                        state_d = CALC;
                    end else if (word_term) begin
                        num_d   = 1'b0;
                        rch_d   = CH_E;
                        idx_d   = '0;
                        state_d = SEND;
                    end else begin
                        state_d = DISCARD;
                    end
                end
            end
            DISCARD: begin
                if (RX_DATA_EN && rx_byte == TERM) begin
                    num_d   = 1'b0;
                    rch_d   = CH_E;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            CALC: state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (CALC_DONE) begin
                    res_d   = CALC_RES;
                    num_d   = !CALC_OVF;
                    rch_d   = CH_V;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (TX_RDY) begin
                    if (idx == last_idx) begin
                        op_a_d  = '0;
                        op_b_d  = '0;
                        cnt_d   = '0;
                        state_d = ACC_A;
                    end else begin
                        idx_d = idx + IW'(1);
                        // Shift so the next digit sits in the top nibble.
                        if (resp_num && idx < DIG_I) res_d = res_q << 4;
                    end
                end
            end
            default: state_d = ACC_A;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ACC_A;
            OP_A      <= '0;
            OP_B      <= '0;
            OPCODE    <= OP_ADD;
            cnt       <= '0;
            res_q     <= '0;
            resp_num  <= 1'b0;
            resp_char <= 8'h00;
            idx       <= '0;
            RX_DROP   <= 1'b0;
        end else begin
            state     <= state_d;
            OP_A      <= op_a_d;
            OP_B      <= op_b_d;
            OPCODE    <= opc_d;
            cnt       <= cnt_d;
            res_q     <= res_d;
            resp_num  <= num_d;
            resp_char <= rch_d;
            idx       <= idx_d;
            RX_DROP   <= RX_DATA_EN && BUSY;
        end
    end

    assign last_idx   = resp_num ? DIG_I + IW'(1) : IW'(2);
    assign CALC_START = (state == CALC);
    assign TX_VALID   = (state == SEND);
    assign BUSY       = (state == CALC) || (state == WAIT_DONE)
                     || (state == SEND);

    always_comb begin
        TX_DATA = 8'h00;
        if (state == SEND) begin
            if (idx == last_idx)                  TX_DATA = CH_LF;
            else if (idx == last_idx - IW'(1))    TX_DATA = CH_CR;
            else if (resp_num)                    TX_DATA = tx_char;
            else                                  TX_DATA = resp_char;
        end
    end

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Scoreboard bench for calc_cmd_sequencer: queued expected TX bytes and
// calculator launches, checked by a free-running monitor.
module tb_calc_cmd_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [9:0]  RX_DATA = '0;
    logic        RX_DATA_EN = 1'b0;
    logic [15:0] OP_A, OP_B;
    logic [1:0]  OPCODE;
    logic        CALC_START;
    logic        CALC_DONE = 1'b0;
    logic [15:0] CALC_RES = '0;
    logic        CALC_OVF = 1'b0;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_RDY = 1'b1;
    logic        BUSY;
    logic        RX_DROP;

    calc_cmd_sequencer #(.DIGITS(4), .TERM(8'h0D)) dut (
        .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_DATA_EN(RX_DATA_EN),
        .OP_A(OP_A), .OP_B(OP_B), .OPCODE(OPCODE), .CALC_START(CALC_START),
        .CALC_DONE(CALC_DONE), .CALC_RES(CALC_RES), .CALC_OVF(CALC_OVF),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_RDY(TX_RDY),
        .BUSY(BUSY), .RX_DROP(RX_DROP)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
    } calc_t;

    logic [7:0]  tx_q[$];
    calc_t       calc_q[$];
    int          checks = 0;
    int          errors = 0;
    int          start_cnt = 0;
    int          drop_cnt = 0;
    logic        auto_calc = 1'b1;
    logic [15:0] rsp_res = '0;
    logic        rsp_ovf = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(logic [7:0] b, logic [1:0] flags);
        RX_DATA    = {flags, b};
        RX_DATA_EN = 1'b1;
        tick();
        RX_DATA_EN = 1'b0;
        tick();
    endtask

    task automatic send_line(string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 2'b00);
        send_byte(8'h0D, 2'b00);
    endtask

    task automatic expect_resp(string s);
        for (int i = 0; i < s.len(); i++) tx_q.push_back(s[i]);
        tx_q.push_back(8'h0D);
        tx_q.push_back(8'h0A);
    endtask

    task automatic expect_calc(logic [15:0] a, logic [15:0] b,
                               logic [1:0] op);
        calc_t e;
        e.a = a;
        e.b = b;
        e.op = op;
        calc_q.push_back(e);
    endtask

    task automatic wait_idle(string name);
        int n = 0;
        while ((tx_q.size() != 0 || BUSY) && n < 400) begin
            tick();
            n++;
        end
        chk({name, "_done"}, n < 400, 1);
        chk({name, "_calc_q"}, calc_q.size(), 0);
        tick();
    endtask

    // Monitor: compares every launch and every accepted TX byte.
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = '0;
    initial forever begin
        @(negedge CLK);
        if (RST) begin
            stall_prev = 1'b0;
        end else begin
            if (RX_DROP) drop_cnt++;
            if (CALC_START) begin
                start_cnt++;
                if (calc_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL calc_start: got pulse expected none");
                end else begin
                    calc_t e;
                    e = calc_q.pop_front();
                    chk("op_a", OP_A, e.a);
                    chk("op_b", OP_B, e.b);
                    chk("opcode", OPCODE, e.op);
                end
            end
            if (stall_prev)
                chk("tx_hold", {TX_VALID, TX_DATA}, {1'b1, stall_data});
            if (TX_VALID && TX_RDY) begin
                if (tx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_byte: got %h expected none", TX_DATA);
                end else begin
                    chk("tx_byte", TX_DATA, tx_q.pop_front());
                end
            end
            stall_prev = TX_VALID && !TX_RDY;
            stall_data = TX_DATA;
        end
    end

    // Arithmetic unit stand-in: answers each launch after a few cycles.
    initial forever begin
        @(negedge CLK);
        if (CALC_START && auto_calc && !RST) begin
            repeat (3) @(posedge CLK);
            #1;
            CALC_DONE = 1'b1;
            CALC_RES  = rsp_res;
            CALC_OVF  = rsp_ovf;
            @(posedge CLK);
            #1;
            CALC_DONE = 1'b0;
            chk("done_to_txv", TX_VALID, 1);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0, s0;
        repeat (3) tick();
        chk("rst_outputs",
            {OP_A, OP_B, OPCODE, CALC_START, TX_DATA, TX_VALID, BUSY, RX_DROP},
            '0);
        RST = 1'b0;
        tick();
        chk("idle_busy", {BUSY, TX_VALID}, 2'b00);

        rsp_res = 16'h0119;
        rsp_ovf = 1'b0;
        expect_calc(16'h001A, 16'h00FF, 2'd0);
        expect_resp("0119");
        send_line("1A+FF");
        wait_idle("add");
        chk("cleared_op_a", OP_A, 0);
        chk("cleared_op_b", OP_B, 0);
        chk("start_cnt1", start_cnt, 1);

        rsp_res = 16'h0000;
        rsp_ovf = 1'b1;
        expect_calc(16'hFFFF, 16'h0002, 2'd2);
        expect_resp("V");
        send_line("ffff*2");
        wait_idle("ovf");

        s0 = start_cnt;
        expect_resp("E");
        send_line("12345+1");
        wait_idle("too_long");
        chk("no_start_long", start_cnt, s0);

        rsp_res = 16'h0001;
        rsp_ovf = 1'b0;
        expect_calc(16'h0003, 16'h0005, 2'd3);
        expect_resp("0001");
        send_line("3&5");
        wait_idle("and");

        s0 = start_cnt;
        expect_resp("E");
        send_byte("1", 2'b00);
        send_byte("2", 2'b00);
        send_byte("+", 2'b01);
        send_byte("3", 2'b00);
        send_byte(8'h0D, 2'b00);
        wait_idle("parity");
        chk("no_start_parity", start_cnt, s0);

        expect_resp("E");
        send_line("+1");
        wait_idle("op_first");

        // Back-pressure on the second result char, with a byte dropped.
        d0 = drop_cnt;
        rsp_res = 16'hA0B7;
        expect_calc(16'h0002, 16'h0001, 2'd1);
        expect_resp("A0B7");
        TX_RDY = 1'b0;
        send_line("2-1");
        for (int n = 0; n < 50 && !TX_VALID; n++) tick();
        chk("stall_txv", TX_VALID, 1);
        TX_RDY = 1'b1;
        tick();
        TX_RDY = 1'b0;
        repeat (5) tick();
        send_byte("7", 2'b00);
        repeat (13) tick();
        chk("stall_data", TX_DATA, 8'h30);
        chk("drop_once", drop_cnt, d0 + 1);
        TX_RDY = 1'b1;
        wait_idle("stall");

        // Reset while waiting on the calculator, then a stray completion.
        auto_calc = 1'b0;
        expect_calc(16'h0007, 16'h0003, 2'd2);
        send_line("7*3");
        repeat (2) tick();
        chk("in_wait", {BUSY, TX_VALID, OP_A}, {1'b1, 1'b0, 16'h0007});
        RST = 1'b1;
        #1;
        chk("rst_async",
            {OP_A, OP_B, OPCODE, CALC_START, TX_DATA, TX_VALID, BUSY, RX_DROP},
            '0);
        tick();
        RST = 1'b0;
        tick();
        CALC_DONE = 1'b1;
        CALC_RES  = 16'h1234;
        tick();
        CALC_DONE = 1'b0;
        repeat (10) tick();
        chk("stray_done", {BUSY, TX_VALID}, 2'b00);
        auto_calc = 1'b1;
        rsp_res = 16'h0002;
        expect_calc(16'h0001, 16'h0001, 2'd0);
        expect_resp("0002");
        send_line("1+1");
        wait_idle("after_rst");
        chk("drop_total", drop_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_cmd_sequencer.md
Name: calc_cmd_sequencer

Overview:
Command sequencer for the serial hex calculator. Consumes 10-bit words from the UART receiver: data[7:0], bit8 parity error, bit9 frame error, qualified by a one-cycle enable. Parses ASCII lines of the form "<hexA><op><hexB><CR>", launches the arithmetic unit, and returns the result as ASCII hex plus CR LF through the UART transmitter. It is the only block that starts the calculator and the only requester of the TX path.

Parameters:
DIGITS, 4, maximum hex digits per operand; operand and result width W = 4*DIGITS.
TERM, 8'h0D, line terminator character (CR).

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous reset, active-high
RX_DATA  in  10  received word: [7:0] byte, [8] parity error, [9] frame error
RX_DATA_EN  in  1  one-cycle strobe, RX_DATA valid
OP_A  out  W  operand A to calculator
OP_B  out  W  operand B to calculator
OPCODE  out  2  '+'=0, '-'=1, '*'=2, '&'=3
CALC_START  out  1  one-cycle launch pulse
CALC_DONE  in  1  one-cycle completion pulse
CALC_RES  in  W  result, valid with CALC_DONE
CALC_OVF  in  1  overflow flag, valid with CALC_DONE
TX_DATA  out  8  byte to transmitter
TX_VALID  out  1  byte offered; held until accepted
TX_RDY  in  1  transmitter accepts when TX_VALID&TX_RDY
BUSY  out  1  high in CALC/WAIT_DONE/SEND
RX_DROP  out  1  one-cycle pulse when a received word is discarded while BUSY

Behaviour:
- Interface: reset RST is asynchronous and active-high; clock is CLK. All state updates on posedge CLK.
- Reset values: OP_A=0, OP_B=0, OPCODE=0, CALC_START=0, TX_DATA=0, TX_VALID=0, BUSY=0, RX_DROP=0. Digit counter is 0, state is ACC_A.
- Reset mid-operation aborts any calculation or transmission immediately. A CALC_DONE arriving after reset is ignored.
- Input decoding, evaluated only on cycles where RX_DATA_EN=1:
  - Hex digits are 0-9, A-F and a-f.
  - Operators are + - * &.
  - TERM ends the line. Any other byte is illegal.
- A word with RX_DATA[8] or RX_DATA[9] set counts as illegal, whatever its byte value.
- ACC_A:
  - Digit with count<DIGITS: OP_A <= {OP_A[W-5:0], nibble}, count++.
  - Operator with count>=1: latch OPCODE, clear count, clear OP_B, go to ACC_B.
  - Digit with count==DIGITS, operator with count==0, TERM, or illegal byte: set err_code='E' and go to DISCARD.
- ACC_B:
  - Digit: same shift rule as ACC_A, into OP_B.
  - TERM with count>=1: go to CALC.
  - Everything else: same as ACC_A errors ('E', DISCARD).
  - Exception: a TERM in either state with an error goes straight to SEND with the error response; there is no DISCARD stage.
- DISCARD: ignore everything until TERM (even a flagged TERM), then go to SEND with response "E",CR,LF.
- CALC: assert CALC_START for exactly one cycle, then go to WAIT_DONE. OP_A, OP_B and OPCODE stay stable from CALC until leaving WAIT_DONE.
- WAIT_DONE: on CALC_DONE, capture CALC_RES and CALC_OVF.
  - OVF=1: response is "V",CR,LF.
  - Otherwise: DIGITS uppercase hex chars, MS nibble first, then CR, LF.
  - Go to SEND.
- Latency: CALC_DONE to the first TX_VALID is 1 cycle.
- SEND:
  - TX_VALID=1 and TX_DATA = current char.
  - On TX_VALID&TX_RDY, advance to the next char on the next cycle. TX_VALID may stay high back-to-back.
  - After LF is accepted: TX_VALID=0, clear OP_A, OP_B and count, go to ACC_A.
  - TX_DATA must not change while TX_VALID=1 and TX_RDY=0.
- Drops: RX_DATA_EN while in CALC, WAIT_DONE or SEND discards the word and pulses RX_DROP in the next cycle. It has no other effect.
- Leading zeros count toward DIGITS. "00001+1" is an error for DIGITS=4.

Decomposition:
- Shared package calc_pkg holds:
  - ASCII constants: CR 8'h0D, LF 8'h0A, 'E', 'V', '+', '-', '*', '&'.
  - Opcode localparams OP_ADD..OP_AND.
  - State encoding: ACC_A, ACC_B, DISCARD, CALC, WAIT_DONE, SEND.
- One sub-module, hex_ascii_conv, is purely combinational:
  - ascii_to_nibble(byte) gives nibble and is_hex.
  - nibble_to_ascii(nibble) gives an uppercase char.
  - The top module instantiates it twice.

Test Plan:
- "1A+FF"CR, TX_RDY=1, calculator returns RES=16'h0119, OVF=0 -> OP_A=16'h001A, OP_B=16'h00FF, OPCODE=0, one CALC_START pulse; TX bytes "0119",CR,LF; back to ACC_A.
- "ffff*2"CR, calculator OVF=1 -> OP_A=16'hFFFF, OPCODE=2; TX "V",CR,LF.
- "12345+1"CR -> no CALC_START; TX "E",CR,LF. Then "3&5"CR parses normally with OP_A=16'h0003.
- "12+3"CR with the '+' word carrying RX_DATA[8]=1 -> DISCARD until CR; TX "E",CR,LF; no CALC_START.
- TX_RDY held low 20 cycles during the second result char -> TX_VALID high and TX_DATA stable throughout. A byte received during SEND pulses RX_DROP once and leaves the response unchanged.
- RST asserted during WAIT_DONE, then a stray CALC_DONE -> all outputs at reset values, no TX_VALID; the next "1+1"CR completes normally.
